// File: rtl/mvm_pkg.sv
// Shared types and saturation helpers for the MVM result path.
package mvm_pkg;

    typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;
    typedef enum logic {DR_IDLE, DR_RUN} dr_state_t;

    localparam int DEF_OW = 8;
    localparam int SAT_MAX_DEF = (1 << (DEF_OW - 1)) - 1;
    localparam int SAT_MIN_DEF = -(1 << (DEF_OW - 1));

    function automatic int sat_max(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_min(input int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage

// File: rtl/mvm_requant.sv
// Combinational requantizer: arithmetic shift, then signed
// saturation to OW bits.
module mvm_requant
    import mvm_pkg::*;
#(
    parameter int B     = 8,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic signed [2*B-1:0] data_in,
    output logic signed [OW-1:0]  data_out
);

    localparam int W = 2 * B;
    localparam logic signed [W-1:0] HI = W'(sat_max(OW));
    localparam logic signed [W-1:0] LO = W'(sat_min(OW));

    logic signed [W-1:0] t;

    assign t = data_in >>> SHIFT;

    always_comb begin
        data_out = t[OW-1:0];
        unique case (1'b1)
            (t > HI): data_out = HI[OW-1:0];
            (t < LO): data_out = LO[OW-1:0];
            default:  data_out = t[OW-1:0];
        endcase
    end

endmodule

// File: rtl/mvm_result_stream.sv
// Captures K MVM result rows into a two-bank buffer and drains
// them as a valid/ready stream while the core computes again.
module mvm_result_stream
    import mvm_pkg::*;
#(
    parameter int K     = 4,
    parameter int B     = 8,
    parameter int OW    = 8,
    parameter int SHIFT = 0,
    parameter int LOG_K = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done_in,
    input  logic signed [2*B-1:0] data_in,
    output logic signed [OW-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [LOG_K-1:0]      out_row,
    output logic                  bank_free,
    output logic                  overflow
);

    localparam logic [LOG_K-1:0] LAST = LOG_K'(K - 1);

    cap_state_t cap_state;
    dr_state_t  dr_state;

    logic [LOG_K-1:0] wcnt;
    logic [LOG_K-1:0] rcnt;
    logic             wb;
    logic             rb;
    logic [1:0]       full;
    logic [OW-1:0]    mem [2][K];

    logic signed [OW-1:0] rq;
    logic       cap_start;
    logic       cap_end;
    logic       fire;
    logic       dr_end;
    logic       cap_idle_nxt;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic [1:0] full_vis;
    logic [1:0] full_nxt;

    mvm_requant #(
        .B    (B),
        .OW   (OW),
        .SHIFT(SHIFT)
    ) u_requant (
        .data_in (data_in),
        .data_out(rq)
    );

    assign cap_start = (cap_state == CAP_IDLE) && done_in && !full[wb];
    assign cap_end   = (cap_state == CAP_RUN) && (wcnt == LAST);
    assign fire      = out_valid && out_ready;
    assign dr_end    = fire && (rcnt == LAST);

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (cap_end) full_set[wb] = 1'b1;
        if (dr_end)  full_clr[rb] = 1'b1;
    end

    // A bank completing this cycle is visible to the drain at once,
    // so back-to-back results switch banks without a bubble.
    assign full_vis = full | full_set;
    assign full_nxt = (full & ~full_clr) | full_set;

    assign cap_idle_nxt = cap_end ||
                          ((cap_state == CAP_IDLE) && !cap_start);

    assign out_row  = rcnt;
    assign out_last = out_valid && (rcnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_state <= CAP_IDLE;
            wcnt      <= '0;
            wb        <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (cap_state)
                CAP_IDLE: begin
                    if (done_in) begin
                        if (full[wb]) begin
                            overflow <= 1'b1;
                        end else begin
                            cap_state <= CAP_RUN;
                            wcnt      <= '0;
                        end
                    end
                end
                CAP_RUN: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LAST) begin
                        cap_state <= CAP_IDLE;
                        wb        <= ~wb;
                    end
                end
                default: cap_state <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap_state == CAP_RUN) begin
            mem[wb][wcnt] <= rq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= '0;
            bank_free <= 1'b1;
        end else begin
            full      <= full_nxt;
            bank_free <= ~&full_nxt && cap_idle_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dr_state  <= DR_IDLE;
            rb        <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (dr_state)
                DR_IDLE: begin
                    if (full_vis[rb]) begin
                        out_data  <= mem[rb][0];
                        out_valid <= 1'b1;
                        rcnt      <= '0;
                        dr_state  <= DR_RUN;
                    end
                end
                DR_RUN: begin
                    if (fire) begin
                        if (rcnt != LAST) begin
                            out_data <= mem[rb][rcnt + 1'b1];
                            rcnt     <= rcnt + 1'b1;
                        end else begin
                            rb   <= ~rb;
                            rcnt <= '0;
                            if (full_vis[~rb]) begin
                                out_data <= mem[~rb][0];
                            end else begin
                                out_valid <= 1'b0;
                                dr_state  <= DR_IDLE;
                            end
                        end
                    end
                end
                default: dr_state <= DR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_result_stream.sv
// Directed bench for mvm_result_stream with a per-cycle
// result-queue model of capture, overflow and drain order.
module tb_mvm_result_stream;

    localparam int K = 4;
    localparam int B = 8;
    localparam int OW = 8;
    localparam int LOG_K = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  done_in = 1'b0;
    logic signed [2*B-1:0] data_in = '0;
    logic                  out_ready = 1'b0;
    logic signed [OW-1:0]  out_data;
    logic                  out_valid;
    logic                  out_last;
    logic [LOG_K-1:0]      out_row;
    logic                  bank_free;
    logic                  overflow;

    logic                  done2 = 1'b0;
    logic signed [2*B-1:0] data2 = '0;
    logic                  ready2 = 1'b1;
    logic signed [OW-1:0]  od2;
    logic                  ov2;
    logic                  ol2;
    logic [LOG_K-1:0]      or2;
    logic                  bf2;
    logic                  of2;

    mvm_result_stream #(
        .K(K), .B(B), .OW(OW), .SHIFT(0), .LOG_K(LOG_K)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .done_in  (done_in),
        .data_in  (data_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .out_row  (out_row),
        .bank_free(bank_free),
        .overflow (overflow)
    );

    mvm_result_stream #(
        .K(K), .B(B), .OW(OW), .SHIFT(2), .LOG_K(LOG_K)
    ) dut_sh (
        .clk      (clk),
        .reset    (reset),
        .done_in  (done2),
        .data_in  (data2),
        .out_data (od2),
        .out_valid(ov2),
        .out_ready(ready2),
        .out_last (ol2),
        .out_row  (or2),
        .bank_free(bf2),
        .overflow (of2)
    );

    int total = 0;
    int bad = 0;

    int exp_q[$];
    int pend[$];
    int got_d[$];
    int got_r[$];
    int got_l[$];
    int m_full = 0;
    int m_cap = 0;
    int m_ridx = 0;
    int m_ovf = 0;
    int m_bf = 1;
    bit armed = 1'b0;
    bit p_stall = 1'b0;
    int p_data, p_row, p_last;
    int run = 0;
    int best = 0;

    task automatic chk(input string name,
                       input logic signed [31:0] act,
                       input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rq(input int x, input int s);
        int t;
        t = x >>> s;
        if (t > 127) return 127;
        if (t < -128) return -128;
        return t;
    endfunction

    // Called once per cycle at the falling edge: checks outputs
    // against the model, then advances the model past the next edge.
    task automatic model_step();
        int f0;
        if (armed) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_without_result", 1, 0);
                end else begin
                    chk("row_data", out_data, exp_q[0]);
                    chk("row_index", out_row, m_ridx);
                    chk("row_last", out_last, int'(m_ridx == K - 1));
                end
            end else begin
                chk("last_when_idle", out_last, 0);
            end
            if (p_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, p_data);
                chk("stall_row", out_row, p_row);
                chk("stall_last", out_last, p_last);
            end
            chk("overflow", overflow, m_ovf);
            chk("bank_free", bank_free, m_bf);
        end
        p_stall = out_valid && !out_ready;
        p_data = out_data;
        p_row = out_row;
        p_last = out_last;
        run = out_valid ? run + 1 : 0;
        if (run > best) best = run;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_r.push_back(out_row);
            got_l.push_back(out_last);
        end
        if (reset) begin
            exp_q.delete();
            pend.delete();
            m_full = 0;
            m_cap = 0;
            m_ridx = 0;
            m_ovf = 0;
            m_bf = 1;
            armed = 1'b1;
            p_stall = 1'b0;
        end else begin
            f0 = m_full;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (m_ridx == K - 1) begin
                    m_ridx = 0;
                    m_full--;
                end else begin
                    m_ridx++;
                end
            end
            if (m_cap > 0) begin
                pend.push_back(rq(data_in, 0));
                m_cap--;
                if (m_cap == 0) begin
                    foreach (pend[i]) exp_q.push_back(pend[i]);
                    pend.delete();
                    m_full++;
                end
            end else if (done_in) begin
                if (f0 == 2) m_ovf = 1;
                else m_cap = K;
            end
            m_bf = int'(m_full < 2 && m_cap == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r [4]);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 16'(r[i]);
            tick();
        end
    endtask

    task automatic wait_rows(input string name, input int n);
        int c;
        c = 0;
        while (got_d.size() < n && c < 40) begin
            tick();
            c++;
        end
        if (got_d.size() < n) chk(name, got_d.size(), n);
    endtask

    task automatic chk_rows(input string name, input int base,
                            input int exp [8], input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < got_d.size()) begin
                chk({name, "_data"}, got_d[base + i], exp[i]);
                chk({name, "_row"}, got_r[base + i], i % K);
                chk({name, "_last"}, got_l[base + i], int'(i % K == K - 1));
            end else begin
                chk({name, "_missing"}, 0, 1);
            end
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_data"}, out_data, 0);
        chk({name, "_last"}, out_last, 0);
        chk({name, "_row"}, out_row, 0);
        chk({name, "_ovf"}, overflow, 0);
        chk({name, "_bfree"}, bank_free, 1);
    endtask

    int base;
    int sh_exp [4] = '{-2, 127, -1, 0};

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("reset");
        chk("reset_sh_valid", ov2, 0);

        // requantization and first-row latency
        out_ready = 1'b1;
        base = got_d.size();
        send('{5, 300, -300, -128});
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_latency_data", out_data, 5);
        wait_rows("t1_rows", base + 4);
        chk_rows("t1", base, '{5, 127, -128, -128, 0, 0, 0, 0}, 4);
        tick();
        chk("t1_bank_free", bank_free, 1);

        // shift instance: floor and saturation after >>> 2
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        data2 = -16'sd7;  tick();
        data2 = 16'sd1000; tick();
        data2 = -16'sd1;  tick();
        data2 = 16'sd3;   tick();
        for (int i = 0; i < 4; i++) begin
            chk("sh_valid", ov2, 1);
            chk("sh_data", od2, sh_exp[i]);
            chk("sh_row", or2, i);
            chk("sh_last", ol2, int'(i == 3));
            tick();
        end
        chk("sh_drained", ov2, 0);

        // backpressure 1,0,0,1
        out_ready = 1'b0;
        base = got_d.size();
        send('{1, 2, 3, 4});
        for (int i = 0; i < 40 && got_d.size() < base + 4; i++) begin
            out_ready = (i % 4 == 0 || i % 4 == 3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        chk("bp_transfers", got_d.size() - base, 4);
        chk_rows("bp", base, '{1, 2, 3, 4, 0, 0, 0, 0}, 4);

        // double buffering and overflow
        out_ready = 1'b0;
        base = got_d.size();
        send('{10, 20, 30, 40});
        send('{-1, -2, -3, -4});
        tick();
        chk("db_bank_free", bank_free, 0);
        chk("db_no_ovf_yet", overflow, 0);
        send('{7, 7, 7, 7});
        tick();
        chk("db_overflow", overflow, 1);
        out_ready = 1'b1;
        wait_rows("db_rows", base + 8);
        tick();
        tick();
        chk("db_transfers", got_d.size() - base, 8);
        chk_rows("db", base, '{10, 20, 30, 40, -1, -2, -3, -4}, 8);
        chk("db_ovf_sticky", overflow, 1);

        // reset during the third capture cycle
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        data_in = 16'sd9;  tick();
        data_in = 16'sd9;  tick();
        data_in = 16'sd9;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("mid_reset");
        base = got_d.size();
        send('{-50, 127, 128, -129});
        wait_rows("rst_rows", base + 4);
        chk_rows("rst", base, '{-50, 127, 127, -128, 0, 0, 0, 0}, 4);

        // back-to-back: second capture overlaps the first drain
        tick();
        out_ready = 1'b0;
        base = got_d.size();
        send('{1, 2, 3, 4});
        best = 0;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        out_ready = 1'b1;
        data_in = 16'sd11; tick();
        data_in = 16'sd12; tick();
        data_in = 16'sd13; tick();
        data_in = 16'sd14; tick();
        wait_rows("b2b_rows", base + 8);
        tick();
        tick();
        chk("b2b_no_bubble", int'(best >= 8), 1);
        chk_rows("b2b", base, '{1, 2, 3, 4, 11, 12, 13, 14}, 8);
        chk("b2b_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
